// File: rtl/soda_vend_sequencer.sv
// Soda machine sequencer: coin credit, price table, vend handshake, change payout.
// Optional TIMEOUT_REFUND_EN: refund credit after 1024 idle cycles in CREDIT.
// Ports: clk, reset (sync, active-low); coin c/a; selection sel_valid/sel_id;
//   cancel; price_we/price_idx/price_wdata; disp_done in; disp_req/disp_id,
//   chg_pulse, coin_reject, sel_nack, credit, busy out.
module soda_vend_sequencer #(
  parameter int NUM_PROD      = 4,
  parameter int PRICE_DEFAULT = 30,
  parameter int CHANGE_UNIT   = 5,
  parameter int CHG_GAP       = 2,
  localparam int IW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c,
  input  logic [7:0]    a,
  input  logic          sel_valid,
  input  logic [IW-1:0] sel_id,
  input  logic          cancel,
  input  logic          price_we,
  input  logic [IW-1:0] price_idx,
  input  logic [7:0]    price_wdata,
  input  logic          disp_done,
  output logic          disp_req,
  output logic [IW-1:0] disp_id,
  output logic          chg_pulse,
  output logic          coin_reject,
  output logic          sel_nack,
  output logic [7:0]    credit,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  localparam logic [7:0] CU  = 8'(CHANGE_UNIT);
  localparam logic [7:0] GAP = 8'(CHG_GAP - 1);

  state_t        state, state_n;
  logic [7:0]    credit_n;
  logic [IW-1:0] disp_id_n;
  logic          pulse_n, rej_n, nack_n;
  logic [7:0]    gap, gap_n;
  logic [7:0]    price [NUM_PROD];
  logic [7:0]    sel_price;
  logic [8:0]    sum;
  logic          sel_go, cancel_go, cancel_eff;

`ifdef TIMEOUT_REFUND_EN
  logic [9:0] idle_cnt;
  logic       idle_fire;

  assign idle_fire = (idle_cnt == 10'd1023);

  always_ff @(posedge clk) begin
    if (!reset || state != CREDIT ||
        c || sel_valid || cancel)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 10'd1;
  end

  assign cancel_eff = cancel | idle_fire;
`else
  assign cancel_eff = cancel;
`endif

  assign sel_price = price[sel_id];
  assign sum       = {1'b0, credit} + {1'b0, a};
  assign disp_req  = (state == VEND);
  assign busy      = (state == VEND) ||
                     (state == CHANGE);

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    disp_id_n = disp_id;
    gap_n     = gap;
    pulse_n   = 1'b0;
    rej_n     = 1'b0;
    nack_n    = 1'b0;
    sel_go    = 1'b0;
    cancel_go = 1'b0;
    unique case (state)
      IDLE, CREDIT: begin
        // Selection sees pre-coin credit; cancel beats selection.
        cancel_go = cancel_eff && (credit >= CU);
        sel_go    = sel_valid && !cancel &&
                    (credit >= sel_price);
        nack_n    = sel_valid && !sel_go;
        if (sel_go) begin
          credit_n  = credit - sel_price;
          disp_id_n = sel_id;
          state_n   = VEND;
          rej_n     = c;
        end else if (cancel_go) begin
          state_n = CHANGE;
          gap_n   = '0;
          rej_n   = c;
        end else if (c && a != 8'd0) begin
          if (sum[8]) begin
            rej_n = 1'b1;
          end else begin
            credit_n = sum[7:0];
            state_n  = CREDIT;
          end
        end
      end
      VEND: begin
        rej_n  = c;
        nack_n = sel_valid;
        if (disp_done) begin
          gap_n = '0;
          if (credit >= CU)
            state_n = CHANGE;
          else if (credit != 8'd0)
            state_n = CREDIT;
          else
            state_n = IDLE;
        end
      end
      CHANGE: begin
        rej_n  = c;
        nack_n = sel_valid;
        if (gap != 8'd0) begin
          gap_n = gap - 8'd1;
        end else if (credit >= CU) begin
          pulse_n  = 1'b1;
          credit_n = credit - CU;
          gap_n    = GAP;
        end else if (credit != 8'd0) begin
          state_n = CREDIT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= '0;
      disp_id     <= '0;
      gap         <= '0;
      chg_pulse   <= 1'b0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;
      for (int i = 0; i < NUM_PROD; i++)
        price[i] <= 8'(PRICE_DEFAULT);
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      disp_id     <= disp_id_n;
      gap         <= gap_n;
      chg_pulse   <= pulse_n;
      coin_reject <= rej_n;
      sel_nack    <= nack_n;
      if (price_we)
        price[price_idx] <= price_wdata;
    end
  end

endmodule

// File: tb/tb_soda_vend_sequencer.sv
// Bench for soda_vend_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the machine.
module tb_soda_vend_sequencer;

  localparam int NP = 4;
  localparam int G  = 2;
  localparam int CU = 5;

  logic       clk = 1'b0;
  logic       reset, c, sel_valid, cancel;
  logic       price_we, disp_done;
  logic [7:0] a, price_wdata;
  logic [1:0] sel_id, price_idx;
  logic       disp_req, chg_pulse, coin_reject;
  logic       sel_nack, busy;
  logic [1:0] disp_id;
  logic [7:0] credit;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pulse_cnt = 0;

  soda_vend_sequencer dut (
    .clk(clk), .reset(reset), .c(c), .a(a),
    .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel), .price_we(price_we),
    .price_idx(price_idx),
    .price_wdata(price_wdata),
    .disp_done(disp_done), .disp_req(disp_req),
    .disp_id(disp_id), .chg_pulse(chg_pulse),
    .coin_reject(coin_reject),
    .sel_nack(sel_nack), .credit(credit),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: mode 0 = taking coins, 1 = vending, 2 = paying change.
  // Payout is a schedule: entered at edge k with n coins owed,
  // pulses land at k+1+i*G and the machine frees up at k+1+n*G.
  int m_mode, m_credit, m_disp;
  int m_start, m_enter;
  int m_price [NP];
  bit m_rej, m_nack, m_pulse;

  always @(posedge clk) begin : model
    int rel, n;
    bit gs, gc;
    if (!reset) begin
      m_mode = 0; m_credit = 0; m_disp = 0;
      m_rej = 0; m_nack = 0; m_pulse = 0;
      for (int i = 0; i < NP; i++) m_price[i] = 30;
    end else begin
      m_rej = 0; m_nack = 0; m_pulse = 0;
      case (m_mode)
        0: begin
          gc = cancel && m_credit >= CU;
          gs = sel_valid && !cancel &&
               m_credit >= m_price[sel_id];
          m_nack = sel_valid && !gs;
          if (gs) begin
            m_credit -= m_price[sel_id];
            m_disp = sel_id;
            m_mode = 1;
          end else if (gc) begin
            m_mode = 2; m_enter = cyc;
            m_start = m_credit;
          end else if (c && a != 0) begin
            if (m_credit + a > 255) m_rej = 1;
            else m_credit += a;
          end
          if ((gs || gc) && c) m_rej = 1;
        end
        1: begin
          m_rej = c; m_nack = sel_valid;
          if (disp_done) begin
            if (m_credit >= CU) begin
              m_mode = 2; m_enter = cyc;
              m_start = m_credit;
            end else m_mode = 0;
          end
        end
        default: begin
          m_rej = c; m_nack = sel_valid;
          rel = cyc - m_enter;
          n = m_start / CU;
          if (rel >= 1 && rel <= 1 + (n - 1) * G &&
              (rel - 1) % G == 0) begin
            m_pulse = 1;
            m_credit -= CU;
          end
          if (rel == 1 + n * G) m_mode = 0;
        end
      endcase
      if (price_we) m_price[price_idx] = price_wdata;
    end
    cyc++;
    #1;
    if (chg_pulse === 1'b1) pulse_cnt++;
    chk("credit", credit, m_credit);
    chk("disp_req", disp_req, m_mode == 1);
    chk("busy", busy, m_mode != 0);
    chk("disp_id", disp_id, m_disp);
    chk("chg_pulse", chg_pulse, m_pulse);
    chk("coin_reject", coin_reject, m_rej);
    chk("sel_nack", sel_nack, m_nack);
  end

  task automatic clr();
    c = 0; a = 0; sel_valid = 0; sel_id = 0;
    cancel = 0; price_we = 0; price_idx = 0;
    price_wdata = 0; disp_done = 0;
  endtask

  task automatic coin(int v);
    c = 1; a = 8'(v);
    @(negedge clk); clr();
  endtask

  task automatic sel(int id);
    sel_valid = 1; sel_id = 2'(id);
    @(negedge clk); clr();
  endtask

  task automatic canc();
    cancel = 1;
    @(negedge clk); clr();
  endtask

  task automatic done();
    disp_done = 1;
    @(negedge clk); clr();
  endtask

  task automatic wr(int idx, int v);
    price_we = 1; price_idx = 2'(idx);
    price_wdata = 8'(v);
    @(negedge clk); clr();
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    clr();
    reset = 0;
    idle(2);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    reset = 1;

    coin(10); coin(20);
    chk("t1_credit30", credit, 30);
    p0 = pulse_cnt;
    sel(0);
    chk("t1_req", disp_req, 1);
    chk("t1_id", disp_id, 0);
    chk("t1_credit0", credit, 0);
    idle(3); done(); idle(6);
    chk("t1_req_low", disp_req, 0);
    chk("t1_nochg", pulse_cnt - p0, 0);

    coin(20); coin(20);
    p0 = pulse_cnt;
    sel(0);
    chk("t2_credit10", credit, 10);
    done(); idle(10);
    chk("t2_pulses", pulse_cnt - p0, 2);
    chk("t2_credit", credit, 0);

    coin(10); sel(0);
    chk("t3_nack", sel_nack, 1);
    chk("t3_credit", credit, 10);
    p0 = pulse_cnt;
    canc(); idle(10);
    chk("t3_pulses", pulse_cnt - p0, 2);
    chk("t3_busy", busy, 0);

    coin(250); coin(10);
    chk("t4_reject", coin_reject, 1);
    chk("t4_credit", credit, 250);
    sel(0); coin(5);
    chk("t4_vend_rej", coin_reject, 1);
    chk("t4_credit220", credit, 220);
    done(); idle(100);
    chk("t4_credit0", credit, 0);

    coin(7);
    p0 = pulse_cnt;
    canc(); idle(8);
    chk("t5_pulses", pulse_cnt - p0, 1);
    chk("t5_credit", credit, 2);
    chk("t5_busy", busy, 0);

    wr(1, 45);
    coin(25); coin(23); sel(0); done(); idle(2);
    chk("t6_in_change", busy, 1);
    reset = 0; @(negedge clk); reset = 1;
    chk("t6_pulse", chg_pulse, 0);
    chk("t6_credit", credit, 0);
    chk("t6_busy", busy, 0);
    coin(30); sel(1);
    chk("t6_default_price", disp_req, 1);
    done(); idle(2);

    wr(2, 0); sel(2);
    chk("t7_free_req", disp_req, 1);
    chk("t7_free_id", disp_id, 2);
    done(); idle(2);

    repeat (3000) begin
      c         = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 6))
        0: a = 8'd5;
        1: a = 8'd10;
        2: a = 8'd25;
        3: a = 8'd7;
        4: a = 8'd1;
        5: a = 8'd100;
        default: a = 8'd200;
      endcase
      sel_valid   = ($urandom_range(0, 99) < 15);
      sel_id      = 2'($urandom_range(0, 3));
      cancel      = ($urandom_range(0, 99) < 5);
      price_we    = ($urandom_range(0, 99) < 5);
      price_idx   = 2'($urandom_range(0, 3));
      price_wdata = 8'($urandom_range(0, 60));
      disp_done   = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    clr();
    reset = 1;
    idle(2);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/soda_vend_sequencer.md
Name: soda_vend_sequencer

Overview:
- Top-level sequencer for a multi-product soda machine.
- Accumulates coin credit, holds a programmable price table, and arbitrates product selection against credit.
- Drives a single shared dispense mechanism with a req/done handshake, then pays change one coin at a time.
- Sits between the coin acceptor / selection buttons and the dispense and change mechanisms.

Parameters:
- NUM_PROD, 4, number of products; sel_id/price_idx width = clog2(NUM_PROD).
- PRICE_DEFAULT, 30, reset value of every price table entry.
- CHANGE_UNIT, 5, value of one change coin.
- CHG_GAP, 2, cycles between consecutive chg_pulse assertions (>=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous active-low reset.
- c  in  1  coin strobe, one cycle per coin.
- a  in  8  coin value, valid when c=1.
- sel_valid  in  1  product selection strobe.
- sel_id  in  clog2(NUM_PROD)  selected product.
- cancel  in  1  refund request.
- price_we  in  1  price table write enable.
- price_idx  in  clog2(NUM_PROD)  price entry index.
- price_wdata  in  8  new price.
- disp_done  in  1  dispense mechanism completion pulse.
- disp_req  out  1  dispense request, held until disp_done.
- disp_id  out  clog2(NUM_PROD)  product being dispensed.
- chg_pulse  out  1  one pulse = one CHANGE_UNIT coin returned.
- coin_reject  out  1  one-cycle pulse; the coin in the same cycle was not credited.
- sel_nack  out  1  one-cycle pulse; the selection was refused.
- credit  out  8  current credit.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE, credit=0, all outputs 0.
  - Every price entry = PRICE_DEFAULT.
  - Overrides every other input, including mid-VEND or mid-CHANGE.
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
- Coin handling in IDLE/CREDIT:
  - If credit+a <= 255: credit <= credit+a next cycle; IDLE->CREDIT when the result is >0.
  - Otherwise: coin_reject pulses next cycle and credit is unchanged.
  - a=0 with c=1 is a no-op, no reject.
- Coins in VEND/CHANGE: always rejected (coin_reject pulses).
- Selection in CREDIT (or IDLE):
  - The chosen price is latched at the selection edge.
  - If credit >= price[sel_id]: credit <= credit-price, disp_id <= sel_id, disp_req=1 from the next cycle, go to VEND.
  - Otherwise: sel_nack pulses and the state is unchanged.
- Selection in VEND/CHANGE: sel_nack.
- Simultaneous coin and selection:
  - The selection is evaluated against the pre-coin credit.
  - If the selection is accepted, the coin is rejected. Otherwise the coin is credited.
- VEND:
  - disp_req stays high until the cycle disp_done=1 is sampled; disp_req drops the next cycle.
  - Then go to CHANGE if credit >= CHANGE_UNIT, else CREDIT (credit>0) or IDLE.
  - disp_done outside VEND is ignored.
- CHANGE:
  - chg_pulse asserts one cycle, then stays low CHG_GAP-1 cycles.
  - credit decrements by CHANGE_UNIT on each pulse.
  - Exit when credit < CHANGE_UNIT: to IDLE if credit=0, else CREDIT. The residue is retained.
- Cancel:
  - In CREDIT with credit >= CHANGE_UNIT: go to CHANGE.
  - In CREDIT with credit < CHANGE_UNIT, or in IDLE/VEND/CHANGE: ignored.
  - Cancel together with sel_valid: cancel wins and the selection is nacked.
- Price writes:
  - Take effect next cycle in any state.
  - A write to the entry being vended does not affect the latched price.
- price_wdata=0 is legal: free vend, needs credit>=0, so it is accepted from IDLE.

Optional Feature:
- TIMEOUT_REFUND_EN:
  - When defined, an inactivity counter runs in CREDIT and clears on any c, sel_valid or cancel.
  - After 1024 idle cycles it behaves as cancel.
  - When undefined, credit is held indefinitely; there is no counter logic.

Test Plan:
- Coins 10 then 20, price[0]=30, select 0 -> disp_req=1, disp_id=0, credit=0; after disp_done, IDLE and no chg_pulse.
- Coins 20+20, select 0 (price 30) -> vend, then exactly 2 chg_pulse spaced CHG_GAP, credit ends 0.
- Coin 10, select 0 (price 30) -> sel_nack pulse, credit stays 10; cancel -> 2 chg_pulse, IDLE.
- Credit 250, coin 10 -> coin_reject, credit 250; coin during VEND -> coin_reject.
- Coin 7, cancel -> 1 chg_pulse, credit 2, state CREDIT.
- reset=0 mid-CHANGE -> next cycle chg_pulse=0, credit=0, all prices 30.
